// File: rtl/addr_select_encoder_if.sv
// Bus bundle for addr_select_encoder: capture inputs, decoded results and serial stream.
// The DUT uses the slave modport; the driver/monitor side uses master.
interface addr_select_encoder_if #(
    parameter int ERR_W = 4
);
    logic             SAMPLE;
    logic [7:0]       AXN;
    logic [7:0]       AX0N_HI;
    logic [7:0]       AYN;
    logic [8:0]       EXP_ADDR;
    logic             CLR_ERR;
    logic [8:0]       ADDR;
    logic [2:0]       GRP_ERR;
    logic             MISMATCH;
    logic             DONE;
    logic             SER_DATA;
    logic             SER_VALID;
    logic             BUSY;
    logic             OVERRUN;
    logic [ERR_W-1:0] ERR_CNT;
    logic [1:0]       dbg_state;

    modport master (
        output SAMPLE, AXN, AX0N_HI, AYN, EXP_ADDR, CLR_ERR,
        input  ADDR, GRP_ERR, MISMATCH, DONE, SER_DATA, SER_VALID, BUSY,
               OVERRUN, ERR_CNT, dbg_state
    );

    modport slave (
        input  SAMPLE, AXN, AX0N_HI, AYN, EXP_ADDR, CLR_ERR,
        output ADDR, GRP_ERR, MISMATCH, DONE, SER_DATA, SER_VALID, BUSY,
               OVERRUN, ERR_CNT, dbg_state
    );
endinterface

// File: rtl/addr_select_encoder.sv
// Reads back the core-memory X/Y drive-line decode, re-encodes it to a 9-bit
// address, checks it against the expected address and shifts it out serially.
module addr_select_encoder #(
    parameter int ERR_W = 4
) (
    input logic                 CLK,
    input logic                 RESET,
    addr_select_encoder_if.slave bus
);
    // Handshake: SAMPLE is accepted only while BUSY is low; a SAMPLE seen while
    // BUSY is dropped and flags OVERRUN. SER_VALID qualifies SER_DATA, no backpressure.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       idx_q;
    logic [7:0]       axn_q, axh_q, ayn_q;
    logic [8:0]       exp_q;
    logic [8:0]       sreg_q;
    logic [8:0]       addr_q;
    logic [2:0]       grp_q;
    logic             mis_q;
    logic             done_q;
    logic             ovr_q;
    logic [ERR_W-1:0] cnt_q;

    logic [3:0]       xl_c, xh_c, y_c;
    logic [8:0]       addr_c;
    logic [2:0]       grp_c;
    logic             mis_c;
    logic             fail_c;
    logic             busy_c, ser_valid_c, ser_data_c;

    // Returns {error, field}: field is the lowest set index, error unless exactly one bit set.
    function automatic logic [3:0] enc_onehot(input logic [7:0] v);
        logic [2:0] f;
        logic [3:0] n;
        f = '0;
        n = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) f = 3'(i);
        end
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return {(n != 4'd1), f};
    endfunction

    always_comb begin
        xl_c   = enc_onehot(~axn_q);
        xh_c   = enc_onehot(~axh_q);
        y_c    = enc_onehot(~ayn_q);
        addr_c = {xh_c[2:0], y_c[2:0], xl_c[2:0]};
        grp_c  = {y_c[3], xh_c[3], xl_c[3]};
        mis_c  = (addr_c != exp_q);
        fail_c = (|grp_c) | mis_c;
    end

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.SAMPLE) state_d = CHECK;
            CHECK:   state_d = SHIFT;
            SHIFT:   if (idx_q == 4'd8) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_c      = (state_q != IDLE);
        ser_valid_c = (state_q == SHIFT);
        ser_data_c  = ser_valid_c & sreg_q[0];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            axn_q  <= '0;
            axh_q  <= '0;
            ayn_q  <= '0;
            exp_q  <= '0;
            sreg_q <= '0;
            idx_q  <= '0;
            addr_q <= '0;
            grp_q  <= '0;
            mis_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == CHECK);
            if (state_q == IDLE && bus.SAMPLE) begin
                axn_q <= bus.AXN;
                axh_q <= bus.AX0N_HI;
                ayn_q <= bus.AYN;
                exp_q <= bus.EXP_ADDR;
            end
            if (state_q == CHECK) begin
                addr_q <= addr_c;
                grp_q  <= grp_c;
                mis_q  <= mis_c;
                sreg_q <= addr_c;
                idx_q  <= '0;
            end
            if (state_q == SHIFT) begin
                sreg_q <= {1'b0, sreg_q[8:1]};
                idx_q  <= idx_q + 4'd1;
            end
        end
    end

    // Error bookkeeping; a clear on the same edge beats an increment or overrun set.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            if (bus.CLR_ERR)
                cnt_q <= '0;
            else if (state_q == CHECK && fail_c && !(&cnt_q))
                cnt_q <= cnt_q + 1'b1;

            if (bus.CLR_ERR)
                ovr_q <= 1'b0;
            else if (bus.SAMPLE && state_q != IDLE)
                ovr_q <= 1'b1;
        end
    end

    assign bus.ADDR      = addr_q;
    assign bus.GRP_ERR   = grp_q;
    assign bus.MISMATCH  = mis_q;
    assign bus.DONE      = done_q;
    assign bus.SER_DATA  = ser_data_c;
    assign bus.SER_VALID = ser_valid_c;
    assign bus.BUSY      = busy_c;
    assign bus.OVERRUN   = ovr_q;
    assign bus.ERR_CNT   = cnt_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_addr_select_encoder.sv
// Directed bench for addr_select_encoder: decode, error flags, serial stream,
// overrun, counter saturation/clear and asynchronous reset.
module tb_addr_select_encoder;
    logic CLK;
    logic RESET;

    addr_select_encoder_if #(.ERR_W(4)) bus ();

    addr_select_encoder #(.ERR_W(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    logic [3:0] exp_cnt  = 4'd0;
    logic       exp_ovr  = 1'b0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_addr"},  32'(bus.ADDR),      32'd0);
        check({pfx, "_grp"},   32'(bus.GRP_ERR),   32'd0);
        check({pfx, "_mis"},   32'(bus.MISMATCH),  32'd0);
        check({pfx, "_done"},  32'(bus.DONE),      32'd0);
        check({pfx, "_sdata"}, 32'(bus.SER_DATA),  32'd0);
        check({pfx, "_svld"},  32'(bus.SER_VALID), 32'd0);
        check({pfx, "_busy"},  32'(bus.BUSY),      32'd0);
        check({pfx, "_ovr"},   32'(bus.OVERRUN),   32'd0);
        check({pfx, "_cnt"},   32'(bus.ERR_CNT),   32'd0);
    endtask

    // One full operation from the SAMPLE edge (E0) to the return to IDLE (E10).
    // Inputs are scrambled after E0 to show only the captured values matter.
    task automatic run_op(input string tag,
                          input logic [7:0] axn, input logic [7:0] axh, input logic [7:0] ayn,
                          input logic [8:0] exp_addr, input logic [8:0] want_addr,
                          input logic [2:0] want_grp, input logic want_mis,
                          input int ovr_at, input int clr_at);
        bus.AXN      = axn;
        bus.AX0N_HI  = axh;
        bus.AYN      = ayn;
        bus.EXP_ADDR = exp_addr;
        for (int n = 0; n <= 10; n++) begin
            bus.SAMPLE  = (n == 0) || (n == ovr_at);
            bus.CLR_ERR = (n == clr_at);
            if (n > 0) begin
                bus.AXN      = 8'($urandom_range(0, 255));
                bus.AX0N_HI  = 8'($urandom_range(0, 255));
                bus.AYN      = 8'($urandom_range(0, 255));
                bus.EXP_ADDR = 9'($urandom_range(0, 511));
            end
            if (n == 1 && (want_grp != 3'b000 || want_mis) && exp_cnt != 4'd15) exp_cnt++;
            if (n == ovr_at && n > 0) exp_ovr = 1'b1;
            if (n == clr_at) begin
                exp_cnt = 4'd0;
                exp_ovr = 1'b0;
            end
            tick();
            bus.SAMPLE  = 1'b0;
            bus.CLR_ERR = 1'b0;
            if (n == 0) begin
                check($sformatf("%s_e0_busy", tag), 32'(bus.BUSY), 32'd1);
                check($sformatf("%s_e0_done", tag), 32'(bus.DONE), 32'd0);
                check($sformatf("%s_e0_svld", tag), 32'(bus.SER_VALID), 32'd0);
            end else if (n == 1) begin
                check($sformatf("%s_e1_done", tag), 32'(bus.DONE), 32'd1);
                check($sformatf("%s_addr", tag), 32'(bus.ADDR), 32'(want_addr));
                check($sformatf("%s_grp", tag), 32'(bus.GRP_ERR), 32'(want_grp));
                check($sformatf("%s_mis", tag), 32'(bus.MISMATCH), 32'(want_mis));
                check($sformatf("%s_cnt", tag), 32'(bus.ERR_CNT), 32'(exp_cnt));
            end
            if (n >= 1 && n <= 9) begin
                check($sformatf("%s_e%0d_svld", tag, n), 32'(bus.SER_VALID), 32'd1);
                check($sformatf("%s_bit%0d", tag, n - 1), 32'(bus.SER_DATA), 32'(want_addr[n - 1]));
            end
            if (n >= 2 && n <= 9) begin
                check($sformatf("%s_e%0d_done", tag, n), 32'(bus.DONE), 32'd0);
                check($sformatf("%s_e%0d_hold", tag, n), 32'(bus.ADDR), 32'(want_addr));
            end
            if (n == 10) begin
                check($sformatf("%s_e10_svld", tag), 32'(bus.SER_VALID), 32'd0);
                check($sformatf("%s_e10_busy", tag), 32'(bus.BUSY), 32'd0);
                check($sformatf("%s_e10_ovr", tag), 32'(bus.OVERRUN), 32'(exp_ovr));
                check($sformatf("%s_e10_cnt", tag), 32'(bus.ERR_CNT), 32'(exp_cnt));
            end
        end
    endtask

    initial begin
        RESET        = 1'b1;
        bus.SAMPLE   = 1'b0;
        bus.CLR_ERR  = 1'b0;
        bus.AXN      = 8'hFF;
        bus.AX0N_HI  = 8'hFF;
        bus.AYN      = 8'hFF;
        bus.EXP_ADDR = 9'h000;
        tick();
        tick();
        check_all_zero("rst");
        RESET = 1'b0;
        tick();

        // Clean decode: X-low 5, Y 1, X-high 3 -> 0x0CD
        run_op("clean", ~8'h20, ~8'h08, ~8'h02, 9'h0CD, 9'h0CD, 3'b000, 1'b0, -1, -1);

        // Multi-hot X-low (bits 1,2) -> lowest index 1
        run_op("multi", ~8'h06, ~8'h08, ~8'h02, 9'h0C9, 9'h0C9, 3'b001, 1'b0, -1, -1);

        // No-hot Y with expected Y field 3 -> one increment only
        run_op("nohot", ~8'h20, ~8'h08, 8'hFF, 9'h0DD, 9'h0C5, 3'b100, 1'b1, -1, -1);

        // Overrun at E5, then a SAMPLE at E11 is accepted
        run_op("ovr", ~8'h20, ~8'h08, ~8'h02, 9'h0CD, 9'h0CD, 3'b000, 1'b0, 5, -1);
        run_op("e11", ~8'h01, ~8'h80, ~8'h40, 9'h1F0, 9'h1F0, 3'b000, 1'b0, -1, -1);

        // Idle clear of counter and overrun
        bus.CLR_ERR = 1'b1;
        tick();
        bus.CLR_ERR = 1'b0;
        exp_cnt = 4'd0;
        exp_ovr = 1'b0;
        check("clr_cnt", 32'(bus.ERR_CNT), 32'd0);
        check("clr_ovr", 32'(bus.OVERRUN), 32'd0);

        // Saturation: 16 failures reach 15, a 17th holds at 15
        for (int i = 0; i < 17; i++) begin
            run_op($sformatf("sat%0d", i), ~8'h20, ~8'h08, 8'hFF, 9'h0DD, 9'h0C5, 3'b100, 1'b1, -1, -1);
        end
        check("sat_final", 32'(bus.ERR_CNT), 32'd15);

        // Clear on the same edge as a failing DONE
        run_op("clrwin", ~8'h20, ~8'h08, 8'hFF, 9'h0DD, 9'h0C5, 3'b100, 1'b1, -1, 1);

        // Reset while bit 4 is on the serial line
        bus.AXN      = ~8'h20;
        bus.AX0N_HI  = ~8'h08;
        bus.AYN      = ~8'h02;
        bus.EXP_ADDR = 9'h0CD;
        bus.SAMPLE   = 1'b1;
        tick();
        bus.SAMPLE = 1'b0;
        repeat (5) tick();
        check("mid_svld", 32'(bus.SER_VALID), 32'd1);
        check("mid_bit4", 32'(bus.SER_DATA), 32'd0);
        #1;
        RESET = 1'b1;
        #1;
        check_all_zero("async_rst");
        tick();
        RESET   = 1'b0;
        exp_cnt = 4'd0;
        exp_ovr = 1'b0;
        tick();
        run_op("post_rst", ~8'h20, ~8'h08, ~8'h02, 9'h0CD, 9'h0CD, 3'b000, 1'b0, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
